// File: rtl/rx_buffer_ctrl_if.sv
// rx_buffer_ctrl_if
//   Bundles the engine-side handshake and the host read port of the
//   receive buffer controller.
//   Engine side : RXRDY, UART_RDATA, RX_Status in; Read out.
//   Host side   : cpu_rd, clr_err in; rd_data, rd_valid, count, empty, full,
//                 err_sticky, rx_int out.
//   slave  : the controller's view.
//   master : the view of whatever drives the engine and host (bench, SoC glue).
interface rx_buffer_ctrl_if #(
    parameter int AW = 4
);
    logic          RXRDY;
    logic [7:0]    UART_RDATA;
    logic [2:0]    RX_Status;
    logic          Read;
    logic          cpu_rd;
    logic [10:0]   rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic [3:0]    err_sticky;
    logic          clr_err;
    logic          rx_int;

    modport slave (
        input  RXRDY, UART_RDATA, RX_Status, cpu_rd, clr_err,
        output Read, rd_data, rd_valid, count, empty, full, err_sticky, rx_int
    );

    modport master (
        output RXRDY, UART_RDATA, RX_Status, cpu_rd, clr_err,
        input  Read, rd_data, rd_valid, count, empty, full, err_sticky, rx_int
    );
endinterface

// File: rtl/rx_buffer_ctrl.sv
// rx_buffer_ctrl
//   Receive-side controller between the UART receive engine and the host.
//   Captures {RX_Status, UART_RDATA} into a DEPTH-entry FIFO when the engine
//   raises RXRDY, pulses Read back to the engine, and serves host pops.
//   Error flags accumulate into err_sticky; rx_int requests host service.
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : rx_buffer_ctrl_if.slave (engine handshake + host read port)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for RXRDY with a free slot
// CAPT  | writing the held byte, Read=1 for this single cycle
// ACK   | byte taken; wait for RXRDY to drop so it is not captured twice
module rx_buffer_ctrl #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    rx_buffer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   THRESH_C = (AW+1)'(THRESH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

    state_t        state, state_nxt;
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count_q;
    logic [10:0]   rd_data_q;
    logic          rd_valid_q;
    logic [3:0]    err_q, err_nxt;
    logic          empty_w, full_w;
    logic          wr_en, pop, underflow;

    assign empty_w   = (count_q == '0);
    assign full_w    = (count_q == DEPTH_C);
    assign pop       = bus.cpu_rd & ~empty_w;
    assign underflow = bus.cpu_rd & empty_w;
    // A pop on the same edge frees the slot a write into a full FIFO would use.
    assign wr_en     = (state == CAPT) & (~full_w | pop);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.RXRDY && !full_w) state_nxt = CAPT;
            CAPT:    state_nxt = ACK;
            ACK:     if (!bus.RXRDY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Storage is deliberately not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (rst && wr_en) mem[wptr] <= {bus.RX_Status, bus.UART_RDATA};
    end

    // Clear first, then OR in this edge's events so a coincident set survives.
    always_comb begin
        err_nxt = bus.clr_err ? 4'b0000 : err_q;
        if (wr_en)     err_nxt[2:0] = err_nxt[2:0] | bus.RX_Status;
        if (underflow) err_nxt[3]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PTR_ONE;
            if (pop) begin
                rptr      <= rptr + PTR_ONE;
                rd_data_q <= mem[rptr];
            end
            rd_valid_q <= pop;
            if (wr_en && !pop)      count_q <= count_q + CNT_ONE;
            else if (!wr_en && pop) count_q <= count_q - CNT_ONE;
            err_q <= err_nxt;
        end
    end

    assign bus.Read       = (state == CAPT);
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.count      = count_q;
    assign bus.empty      = empty_w;
    assign bus.full       = full_w;
    assign bus.err_sticky = err_q;
    assign bus.rx_int     = (count_q >= THRESH_C) | (|err_q);

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// tb_rx_buffer_ctrl
//   Table of single-byte capture/pop vectors, directed multi-cycle sequences
//   (full FIFO, underflow, clear-vs-set, coincident write/pop, mid-frame
//   reset), then randomized engine/host traffic against a queue-based model.
module tb_rx_buffer_ctrl;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rx_buffer_ctrl_if #(.AW(4)) bus();

    rx_buffer_ctrl #(.DEPTH(DEPTH), .AW(4), .THRESH(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  data;
        logic [2:0]  st;
        logic [10:0] rd;
        logic [3:0]  err;
    } vec_t;

    vec_t tbl[5];

    // reference model state for the random phase
    logic [10:0] mq[$];
    logic [10:0] m_rd_data;
    logic        m_rd_valid;
    logic [3:0]  m_err;
    logic        m_read;
    logic        m_taken;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input bit check);
        rst            = 1'b0;
        bus.RXRDY      = 1'b0;
        bus.UART_RDATA = 8'h00;
        bus.RX_Status  = 3'b000;
        bus.cpu_rd     = 1'b0;
        bus.clr_err    = 1'b0;
        tick();
        tick();
        if (check) begin
            chk("rst_count",  32'(bus.count), 32'd0);
            chk("rst_empty",  32'(bus.empty), 32'd1);
            chk("rst_full",   32'(bus.full), 32'd0);
            chk("rst_read",   32'(bus.Read), 32'd0);
            chk("rst_rvalid", 32'(bus.rd_valid), 32'd0);
            chk("rst_rdata",  32'(bus.rd_data), 32'd0);
            chk("rst_err",    32'(bus.err_sticky), 32'd0);
            chk("rst_irq",    32'(bus.rx_int), 32'd0);
        end
        rst = 1'b1;
    endtask

    // Present one byte, let it be captured, drop RXRDY; ends back in IDLE.
    task automatic send_byte(input logic [7:0] d, input logic [2:0] s);
        bus.RXRDY      = 1'b1;
        bus.UART_RDATA = d;
        bus.RX_Status  = s;
        tick();
        tick();
        bus.RXRDY = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input string name, input logic [10:0] exp);
        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
        chk({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({name, "_data"},  32'(bus.rd_data), 32'(exp));
    endtask

    // One clock edge of the model, using the inputs about to be sampled.
    task automatic model_step();
        int          size0;
        logic        p, uf;
        logic [3:0]  e;
        size0 = mq.size();
        p  = bus.cpu_rd && (size0 > 0);
        uf = bus.cpu_rd && (size0 == 0);
        m_rd_valid = p;
        if (p) m_rd_data = mq.pop_front();
        e = bus.clr_err ? 4'b0000 : m_err;
        if (uf) e[3] = 1'b1;
        if (m_read) begin
            e[2:0] = e[2:0] | bus.RX_Status;
            mq.push_back({bus.RX_Status, bus.UART_RDATA});
            m_read  = 1'b0;
            m_taken = 1'b1;
        end else if (!m_taken && bus.RXRDY && size0 < DEPTH) begin
            m_read = 1'b1;
        end else if (m_taken && !bus.RXRDY) begin
            m_taken = 1'b0;
        end
        m_err = e;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       eng_seen;
        int         rd_pct;
        tbl[0] = '{data: 8'h5A, st: 3'b000, rd: 11'h05A, err: 4'b0000};
        tbl[1] = '{data: 8'hA3, st: 3'b011, rd: 11'h3A3, err: 4'b0011};
        tbl[2] = '{data: 8'hFF, st: 3'b100, rd: 11'h4FF, err: 4'b0100};
        tbl[3] = '{data: 8'h00, st: 3'b010, rd: 11'h200, err: 4'b0010};
        tbl[4] = '{data: 8'hC3, st: 3'b111, rd: 11'h7C3, err: 4'b0111};

        // ---- table: single capture then pop, fresh reset each time ----
        for (int i = 0; i < 5; i++) begin
            do_reset(i == 0);
            bus.RXRDY      = 1'b1;
            bus.UART_RDATA = tbl[i].data;
            bus.RX_Status  = tbl[i].st;
            tick();
            chk("t_read_hi",  32'(bus.Read), 32'd1);
            chk("t_count0",   32'(bus.count), 32'd0);
            tick();
            chk("t_read_lo",  32'(bus.Read), 32'd0);
            chk("t_count1",   32'(bus.count), 32'd1);
            chk("t_irq",      32'(bus.rx_int), 32'd1);
            chk("t_err",      32'(bus.err_sticky), 32'(tbl[i].err));
            bus.RXRDY = 1'b0;
            tick();
            pop_expect("t_pop", tbl[i].rd);
            chk("t_count_pop", 32'(bus.count), 32'd0);
            tick();
            chk("t_valid_lo", 32'(bus.rd_valid), 32'd0);
            chk("t_hold",     32'(bus.rd_data), 32'(tbl[i].rd));
            chk("t_irq_after", 32'(bus.rx_int), 32'(tbl[i].err != 4'b0000));
        end

        // ---- fill to full, 17th byte blocked until a pop ----
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 3'b000);
        chk("full_count", 32'(bus.count), 32'd16);
        chk("full_flag",  32'(bus.full), 32'd1);
        bus.RXRDY      = 1'b1;
        bus.UART_RDATA = 8'h10;
        bus.RX_Status  = 3'b000;
        tick();
        chk("full_noread1", 32'(bus.Read), 32'd0);
        tick();
        chk("full_noread2", 32'(bus.Read), 32'd0);
        chk("full_hold",    32'(bus.count), 32'd16);
        pop_expect("full_pop", 11'h000);
        chk("full_count15", 32'(bus.count), 32'd15);
        tick();
        chk("full_read17", 32'(bus.Read), 32'd1);
        tick();
        chk("full_count16", 32'(bus.count), 32'd16);
        bus.RXRDY = 1'b0;
        tick();

        // ---- capture coincident with pop: count unchanged, order kept ----
        bus.RXRDY      = 1'b1;
        bus.UART_RDATA = 8'h11;
        bus.cpu_rd     = 1'b1;
        tick();
        chk("co_pop1",  32'(bus.rd_data), 32'h001);
        tick();
        chk("co_pop2",  32'(bus.rd_data), 32'h002);
        chk("co_read",  32'(bus.Read), 32'd1);
        chk("co_cnt_a", 32'(bus.count), 32'd14);
        tick();
        chk("co_pop3",  32'(bus.rd_data), 32'h003);
        chk("co_cnt_b", 32'(bus.count), 32'd14);
        bus.cpu_rd = 1'b0;
        bus.RXRDY  = 1'b0;
        tick();
        for (int i = 4; i <= 17; i++) pop_expect("co_drain", 11'(i));
        chk("co_empty", 32'(bus.empty), 32'd1);

        // ---- underflow ----
        bus.cpu_rd = 1'b1;
        tick();
        bus.cpu_rd = 1'b0;
        chk("uf_valid", 32'(bus.rd_valid), 32'd0);
        chk("uf_hold",  32'(bus.rd_data), 32'h011);
        chk("uf_err",   32'(bus.err_sticky), 32'h8);
        chk("uf_irq",   32'(bus.rx_int), 32'd1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        chk("uf_clr",     32'(bus.err_sticky), 32'h0);
        chk("uf_clr_irq", 32'(bus.rx_int), 32'd0);

        // ---- clear coincident with a new PERR capture ----
        send_byte(8'hA3, 3'b011);
        chk("cs_err_a", 32'(bus.err_sticky), 32'h3);
        bus.RXRDY      = 1'b1;
        bus.UART_RDATA = 8'h44;
        bus.RX_Status  = 3'b001;
        tick();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        bus.RXRDY   = 1'b0;
        chk("cs_err_b", 32'(bus.err_sticky), 32'h1);
        tick();

        // ---- reset during ACK with RXRDY held ----
        do_reset(1'b0);
        bus.RXRDY      = 1'b1;
        bus.UART_RDATA = 8'h77;
        bus.RX_Status  = 3'b000;
        tick();
        tick();
        chk("mr_cnt_pre", 32'(bus.count), 32'd1);
        rst = 1'b0;
        tick();
        chk("mr_cnt_rst", 32'(bus.count), 32'd0);
        chk("mr_read_rst", 32'(bus.Read), 32'd0);
        rst = 1'b1;
        tick();
        chk("mr_read", 32'(bus.Read), 32'd1);
        tick();
        chk("mr_cnt1", 32'(bus.count), 32'd1);
        tick();
        tick();
        chk("mr_noread", 32'(bus.Read), 32'd0);
        chk("mr_cnt_hold", 32'(bus.count), 32'd1);
        bus.RXRDY = 1'b0;
        tick();
        pop_expect("mr_pop", 11'h077);

        // ---- random traffic against the queue model ----
        do_reset(1'b0);
        mq.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_err      = '0;
        m_read     = 1'b0;
        m_taken    = 1'b0;
        eng_seen   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rd_pct = (c < 1000) ? 12 : ((c < 2000) ? 50 : 88);
            if (bus.Read) eng_seen = 1'b1;
            if (!bus.RXRDY) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.RXRDY      = 1'b1;
                    bus.UART_RDATA = 8'($urandom);
                    bus.RX_Status  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
                    eng_seen       = 1'b0;
                end
            end else if (eng_seen && $urandom_range(0, 1) == 0) begin
                bus.RXRDY = 1'b0;
                eng_seen  = 1'b0;
            end
            bus.cpu_rd  = ($urandom_range(0, 99) < rd_pct);
            bus.clr_err = ($urandom_range(0, 31) == 0);
            model_step();
            tick();
            chk("r_count",  32'(bus.count), 32'(mq.size()));
            chk("r_read",   32'(bus.Read), 32'(m_read));
            chk("r_valid",  32'(bus.rd_valid), 32'(m_rd_valid));
            chk("r_data",   32'(bus.rd_data), 32'(m_rd_data));
            chk("r_err",    32'(bus.err_sticky), 32'(m_err));
            chk("r_irq",    32'(bus.rx_int), 32'((mq.size() >= 1) || (m_err != 4'b0000)));
            chk("r_full",   32'(bus.full), 32'(mq.size() == DEPTH));
            chk("r_empty",  32'(bus.empty), 32'(mq.size() == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
